// File: rtl/max_stream_driver_pkg.sv
// rtl/max_stream_driver_pkg.sv - shared widths, FSM states and record layout for the stream driver
package max_stream_driver_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 3;
  localparam int DEPTH  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEND,
    ST_WAIT,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] instr;
    logic [SEL_W-1:0]  sel;
  } record_t;

endpackage

// File: rtl/max_stream_driver_if.sv
// rtl/max_stream_driver_if.sv - framed operand stream towards the second-maximum finder
interface max_stream_driver_if import max_stream_driver_pkg::*; ();

  logic              start;
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] data_c;
  logic [DATA_W-1:0] instruction;
  logic [SEL_W-1:0]  select;
  logic [DATA_W-1:0] result;

  modport master (
    output start, count, valid, data_a, data_b, data_c, instruction, select,
    input  result
  );

  modport slave (
    input  start, count, valid, data_a, data_b, data_c, instruction, select,
    output result
  );

endinterface

// File: rtl/max_stream_slots.sv
// rtl/max_stream_slots.sv - record register file, one write port and one combinational read port
module max_stream_slots import max_stream_driver_pkg::*; #(
  parameter int N_SLOTS = DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_addr_i,
  input  record_t          wr_data_i,
  input  logic [CNT_W-1:0] rd_addr_i,
  output record_t          rd_data_o
);

  record_t slot_q [N_SLOTS];

  // Addresses beyond the last slot are silently dropped on write and read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
    end else if (wr_en_i && (int'(wr_addr_i) < N_SLOTS)) begin
      slot_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (int'(rd_addr_i) < N_SLOTS) ? slot_q[rd_addr_i] : '0;

endmodule

// File: rtl/max_stream_driver.sv
// rtl/max_stream_driver.sv - replays buffered operand records as one framed stream and captures the reply
module max_stream_driver import max_stream_driver_pkg::*; #(
  parameter int RESULT_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic [CNT_W-1:0]  load_addr_i,
  input  logic [DATA_W-1:0] load_a_i,
  input  logic [DATA_W-1:0] load_b_i,
  input  logic [DATA_W-1:0] load_c_i,
  input  logic [DATA_W-1:0] load_instr_i,
  input  logic [SEL_W-1:0]  load_sel_i,
  input  logic              go_i,
  input  logic [CNT_W-1:0]  n_items_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_out_o,
  output logic              done_o,
  max_stream_driver_if.master strm
);

  localparam int WAIT_W = (RESULT_WAIT < 2) ? 1 : $clog2(RESULT_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_BEAT  = WAIT_W'(RESULT_WAIT);
  // With no beats the header cycle itself is the reference, one cycle earlier than WAIT entry.
  localparam logic [WAIT_W-1:0] WAIT_EMPTY = WAIT_W'(RESULT_WAIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              start_q, start_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  record_t           beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;

  record_t           rd_rec;
  record_t           wr_rec;
  logic              issue;
  logic              last_beat;
  logic              capture;

  assign wr_rec = '{a: load_a_i, b: load_b_i, c: load_c_i, instr: load_instr_i, sel: load_sel_i};

  max_stream_slots #(.N_SLOTS(DEPTH)) u_slots (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (load_en_i && (state_q == ST_IDLE)),
    .wr_addr_i (load_addr_i),
    .wr_data_i (wr_rec),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_rec)
  );

  // A beat is launched on the edge leaving HDR or SEND, so the header is followed directly by data.
  assign issue     = ((state_q == ST_HDR) || (state_q == ST_SEND)) && (n_q != '0) && !hold_i;
  assign last_beat = issue && (idx_q == n_q - CNT_W'(1));
  assign capture   = (state_q == ST_WAIT) && (wait_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          state_d = ST_HDR;
          n_d     = n_items_i;
          idx_d   = '0;
        end
      end
      ST_HDR, ST_SEND: begin
        if (n_q == '0) begin
          state_d = ST_WAIT;
          wait_d  = WAIT_EMPTY;
        end else begin
          state_d = ST_SEND;
          if (issue) idx_d = idx_q + CNT_W'(1);
          if (last_beat) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_BEAT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_FIN;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_d  = (state_d == ST_HDR);
    count_d  = start_d ? n_d : '0;
    valid_d  = issue;
    beat_d   = issue ? rd_rec : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FIN);
    result_d = capture ? strm.result : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      start_q  <= start_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign strm.start       = start_q;
  assign strm.count       = count_q;
  assign strm.valid       = valid_q;
  assign strm.data_a      = beat_q.a;
  assign strm.data_b      = beat_q.b;
  assign strm.data_c      = beat_q.c;
  assign strm.instruction = beat_q.instr;
  assign strm.select      = beat_q.sel;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign result_out_o     = result_q;

endmodule

// File: tb/tb_max_stream_driver.sv
// tb/tb_max_stream_driver.sv - frame-level bench for max_stream_driver with a second-maximum consumer
module tb_max_stream_driver;
  import max_stream_driver_pkg::*;

  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [2:0] load_addr = '0;
  record_t    ld = '0;
  logic       go = 1'b0;
  logic [2:0] n_items = '0;
  logic       hold = 1'b0;
  logic       busy, done;
  logic [7:0] result_out;

  always #5 clk = ~clk;

  max_stream_driver_if strm ();

  max_stream_driver #(.RESULT_WAIT(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en_i    (load_en),
    .load_addr_i  (load_addr),
    .load_a_i     (ld.a),
    .load_b_i     (ld.b),
    .load_c_i     (ld.c),
    .load_instr_i (ld.instr),
    .load_sel_i   (ld.sel),
    .go_i         (go),
    .n_items_i    (n_items),
    .hold_i       (hold),
    .busy_o       (busy),
    .result_out_o (result_out),
    .done_o       (done),
    .strm         (strm)
  );

  // Consumer: running second maximum of data_A over the current frame.
  logic [7:0] m1, m2;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '0; m2 <= '0;
    end else if (strm.start) begin
      m1 <= '0; m2 <= '0;
    end else if (strm.valid) begin
      if (strm.data_a > m1) begin
        m2 <= m1; m1 <= strm.data_a;
      end else if (strm.data_a > m2) begin
        m2 <= strm.data_a;
      end
    end
  end
  assign strm.result = m2;

  record_t    mdl [7];
  logic [7:0] prev_res = '0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int         preload;
    int         n;
    logic [31:0] hmask;
    int         exp_done;
    logic [7:0] exp_res;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {14'b0, busy, strm.start, strm.count, strm.valid, strm.data_a, strm.data_b,
            strm.data_c, strm.instruction, strm.select, done, result_out};
  endfunction

  function automatic logic [63:0] pack(input logic b, input logic s, input logic [2:0] cnt,
                                       input logic v, input record_t r, input logic d,
                                       input logic [7:0] res);
    return {14'b0, b, s, cnt, v, r, d, res};
  endfunction

  function automatic record_t rand_rec();
    record_t r;
    r.a = 8'($urandom); r.b = 8'($urandom); r.c = 8'($urandom);
    r.instr = 8'($urandom); r.sel = 3'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slot(input int addr, input record_t rec);
    load_en = 1'b1; load_addr = 3'(addr); ld = rec;
    tick();
    load_en = 1'b0;
    if (addr < 7) mdl[addr] = rec;
  endtask

  // Cycle 0 is the cycle in which go is driven; cycle c starts at the c-th edge after it.
  // hmask bit c is the hold level presented to the edge that opens cycle c.
  task automatic run_frame(input int n, input logic [31:0] hmask, input bit coload,
                           input record_t co, input bit poke,
                           output int act_done, output logic [7:0] act_res);
    int         beat_c[$];
    logic [7:0] av[$];
    int         k, last, dcyc;
    logic [7:0] exp_res;
    record_t    r;
    logic       v;
    if (coload) mdl[0] = co;
    k = 0;
    for (int c = 2; k < n; c++) begin
      if (!(c < 32 && hmask[c])) begin
        beat_c.push_back(c);
        k++;
      end
    end
    last = (n == 0) ? 1 : beat_c[n-1];
    dcyc = last + RW + 1;
    for (int i = 0; i < n; i++) av.push_back(mdl[i].a);
    av.push_back(8'd0);
    av.push_back(8'd0);
    av.rsort();
    exp_res = av[1];
    act_done = -1;
    act_res = '0;
    go = 1'b1; n_items = 3'(n); hold = hmask[1];
    if (coload) begin
      load_en = 1'b1; load_addr = 3'd0; ld = co;
    end
    k = 0;
    for (int c = 1; c <= dcyc + 1; c++) begin
      tick();
      go = 1'b0; load_en = 1'b0;
      hold = (c + 1 < 32) ? hmask[c+1] : 1'b0;
      if (poke && c == 2) begin
        go = 1'b1; n_items = 3'(7 - n);
        load_en = 1'b1; load_addr = 3'd1; ld = ~mdl[1];
      end
      if (k < n && beat_c[k] == c) begin
        r = mdl[k]; v = 1'b1; k++;
      end else begin
        r = '0; v = 1'b0;
      end
      if (done && act_done < 0) begin
        act_done = c; act_res = result_out;
      end
      check($sformatf("frame n=%0d cycle %0d", n, c), obs(),
            pack(c <= dcyc, c == 1, (c == 1) ? 3'(n) : 3'd0, v, r, c == dcyc,
                 (c >= dcyc) ? exp_res : prev_res));
    end
    prev_res = exp_res;
    hold = 1'b0;
  endtask

  initial begin
    int         ad;
    logic [7:0] ar;
    record_t    co;

    for (int i = 0; i < 7; i++) mdl[i] = '0;
    vecs[0] = '{1, 3, 32'h0, 7, 8'd12};
    vecs[1] = '{0, 3, 32'h8, 8, 8'd12};
    vecs[2] = '{0, 0, 32'h0, 4, 8'd0};
    vecs[3] = '{2, 7, 32'h0, 11, 8'd6};

    tick(); tick();
    check("reset outputs", obs(), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", obs(), 64'd0);

    foreach (vecs[v]) begin
      if (vecs[v].preload == 1) begin
        load_slot(0, '{a: 8'd5,  b: 8'd9, c: 8'd1, instr: 8'h01, sel: 3'd0});
        load_slot(1, '{a: 8'd20, b: 8'd3, c: 8'd4, instr: 8'h02, sel: 3'd1});
        load_slot(2, '{a: 8'd12, b: 8'd7, c: 8'd8, instr: 8'h03, sel: 3'd2});
      end else if (vecs[v].preload == 2) begin
        for (int i = 0; i < 7; i++)
          load_slot(i, '{a: 8'(i + 1), b: 8'(8'h10 + i), c: 8'(8'h20 + i), instr: 8'(8'h30 + i), sel: 3'(i)});
        load_slot(7, '{a: 8'hff, b: 8'hff, c: 8'hff, instr: 8'hff, sel: 3'd7});
      end
      run_frame(vecs[v].n, vecs[v].hmask, 1'b0, '0, 1'b0, ad, ar);
      check($sformatf("vec %0d done cycle", v), 64'(ad), 64'(vecs[v].exp_done));
      check($sformatf("vec %0d result", v), 64'(ar), 64'(vecs[v].exp_res));
    end

    co = '{a: 8'h77, b: 8'h11, c: 8'h22, instr: 8'h33, sel: 3'd5};
    run_frame(3, 32'h0, 1'b1, co, 1'b1, ad, ar);
    check("coload done cycle", 64'(ad), 64'd7);

    go = 1'b1; n_items = 3'd5;
    tick();
    go = 1'b0;
    tick(); tick();
    check("beat 2 before reset", 64'(strm.valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mid-frame", obs(), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) mdl[i] = '0;
    prev_res = '0;
    tick();
    check("idle after abort", obs(), 64'd0);
    run_frame(1, 32'h0, 1'b0, '0, 1'b0, ad, ar);
    check("zero frame done cycle", 64'(ad), 64'd5);

    for (int t = 0; t < 25; t++) begin
      int nl;
      nl = $urandom_range(0, 3);
      for (int j = 0; j < nl; j++) load_slot($urandom_range(0, 7), rand_rec());
      run_frame($urandom_range(0, 7), $urandom & $urandom, $urandom_range(0, 3) == 0,
                rand_rec(), $urandom_range(0, 3) == 0, ad, ar);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max_stream_driver.md
Name: max_stream_driver

Overview:
- Transmit-side counterpart of the second-maximum finder: buffers up to 7 operand records and replays them as one framed stream.
- Stream format: a one-cycle start/count frame header, then valid-qualified beats of data_A/B/C, instruction and select.
- After the last beat it waits a fixed latency, captures the consumer's second_maximum, and reports it with a done pulse.
- Sits between a host/test controller and the finder in the CAD lab datapath.

Parameters:
DATA_W, 8, width of data_A/B/C, instruction and result
DEPTH, 7, record slots (max count encodable in 3 bits)
RESULT_WAIT, 2, cycles from last valid beat to result capture

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_en  input  1  write one record slot
load_addr  input  3  slot index 0..6
load_a  input  8  record data_A
load_b  input  8  record data_B
load_c  input  8  record data_C
load_instr  input  8  record instruction
load_sel  input  3  record select
go  input  1  launch a frame
n_items  input  3  records to send, sampled with go
hold  input  1  stall; suppress valid this cycle
busy  output  1  frame in progress
start  output  1  frame header pulse
count  output  3  item count, meaningful while start=1
valid  output  1  beat qualifier
data_A  output  8  beat operand A
data_B  output  8  beat operand B
data_C  output  8  beat operand C
instruction  output  8  beat opcode
select  output  3  beat select
result_in  input  8  consumer second_maximum
result_out  output  8  captured result
done  output  1  one-cycle pulse, result_out updated

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all outputs 0; FSM=IDLE; all slots cleared to 0; index and wait counter 0. Reset mid-frame aborts immediately, with no further start/valid.
- All outputs registered.
- FSM states: IDLE, HDR, SEND, WAIT, FIN.
- IDLE:
  - load_en writes slot[load_addr]; addr 7 is ignored.
  - go=1 latches n_items and goes to HDR.
  - go and load_en in the same cycle: load takes effect first, so the frame sees the new data.
- HDR (1 cycle): start=1, count=latched n. n=0 -> WAIT; else -> SEND with index=0.
- SEND:
  - hold=0: valid=1 with slot[index] fields, index++; after beat n-1 -> WAIT.
  - hold=1: valid=0, index unchanged; beats may be non-contiguous.
- Data buses drive 0 whenever valid=0. start and valid are never high in the same cycle.
- WAIT:
  - Counter loaded with RESULT_WAIT on entry; decrements each cycle.
  - result_in is captured into result_out at the edge ending cycle L+RESULT_WAIT, where L is the last-beat cycle (or the HDR cycle when n=0).
  - Then -> FIN.
- FIN (1 cycle): done=1 -> IDLE.
- result_out holds until the next capture.
- busy=1 in HDR, SEND, WAIT and FIN.
- While busy, go and load_en are ignored; slot contents are frozen for the frame.
- Nominal latency, no hold: go at cycle 0 -> start in cycle 1 -> beats in cycles 2..n+1 -> done in cycle n+RESULT_WAIT+2.

Decomposition:
- Shared package:
  - DATA_W, SEL_W=3, CNT_W=3
  - FSM state enum
  - record struct {a, b, c, instr, sel}
- One sub-module: max_stream_slots, a DEPTH-entry register file with async-reset write port and combinational read.
- FSM and counters stay in the top.

Test Plan:
- Load slots 0..2 = (A=5,B=9,C=1,instr=0x01,sel=0), (A=20…), (A=12…); go with n_items=3 and no hold -> start with count=3 in cycle 1; valid in cycles 2,3,4 with A=5,20,12; done in cycle 7. With a behavioural finder model that passes A, result_out=12.
- Same load; hold high in cycle 3 -> beats in cycles 2,4,5; valid low and buses 0 in cycle 3; done in cycle 8.
- n_items=0 -> start with count=0; no valid beats; done in cycle 4; result_out captures result_in (model gives 0).
- go and load_en in the same IDLE cycle writing slot0 A=0x77 -> first beat carries A=0x77. A second go or load while busy=1 -> ignored; stream unchanged.
- rst_n low during beat 2 of 5 -> outputs 0 asynchronously and slots 0. After release, go with n_items=1 -> single beat with all fields 0.
- n_items=7 with all slots loaded (A=1..7) -> 7 contiguous beats in address order; done in cycle 11. A load to addr 7 beforehand does not alter any slot.
